// File: rtl/commu_rx.sv
// -----------------------------------------------------------------------------
// commu_rx
// Serial receive-and-check stage of the link test. Recovers bits from the
// asynchronous rx line using a phase accumulator that is re-centred on every
// line edge. Each data bit is compared with a local PRBS7 reference
// (x^7+x^6+1, seed 7'h7F). Matches and mismatches are counted per frame.
//
// Ports
//   clk_sys    : system clock, the only clock used by the block
//   rst_n      : asynchronous active-low reset
//   rx         : serial line, asynchronous, idles high
//   tbit_fre   : bit rate in kbps (16 bit), static during a frame
//   tx_total   : number of data bits per frame (32 bit)
//   rx_total   : data bits that matched the PRBS (32 bit)
//   rx_err     : data bits that mismatched the PRBS (32 bit)
//   rx_busy    : high while a frame is being received
//   frame_done : one-cycle pulse at the end of each frame
// -----------------------------------------------------------------------------
module commu_rx #(
    parameter int unsigned CLK_KHZ = 100000
) (
    input  logic        clk_sys,
    input  logic        rst_n,
    input  logic        rx,
    input  logic [15:0] tbit_fre,
    input  logic [31:0] tx_total,
    output logic [31:0] rx_total,
    output logic [31:0] rx_err,
    output logic        rx_busy,
    output logic        frame_done
);

    localparam logic [31:0] LP_CLK  = 32'(CLK_KHZ);
    localparam logic [31:0] LP_HALF = 32'(CLK_KHZ / 2);
    localparam logic [6:0]  LP_SEED = 7'h7F;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // One PRBS7 step: shift left, feed back lfsr[6]^lfsr[5]
    function automatic logic [6:0] f_lfsr_next(input logic [6:0] s);
        return {s[5:0], s[6] ^ s[5]};
    endfunction

    state_t      r_state;
    logic        r_rx_meta;
    logic        r_rx_s;
    logic        r_rx_d;
    logic [31:0] r_acc;
    logic [6:0]  r_lfsr;
    logic [31:0] r_bit_cnt;
    logic [31:0] r_rx_total;
    logic [31:0] r_rx_err;
    logic        r_busy;
    logic        r_frame_done;

    logic [32:0] w_acc_sum;
    logic        w_tick;
    logic [31:0] w_acc_run;
    logic        w_fall;
    logic        w_edge;
    logic        w_expect;
    logic [31:0] w_bit_next;

    // Accumulator arithmetic, edge detection and expected PRBS bit
    always_comb begin
        w_acc_sum  = {1'b0, r_acc} + {17'd0, tbit_fre};
        w_tick     = (w_acc_sum >= {1'b0, LP_CLK});
        w_fall     = r_rx_d & ~r_rx_s;
        w_edge     = r_rx_d ^ r_rx_s;
        w_expect   = r_lfsr[6] ^ r_lfsr[5];
        w_bit_next = r_bit_cnt + 32'd1;
        // An edge always wins over the free-running phase so the next tick
        // lands mid-bit; the tick's own sample is still taken this cycle.
        if (w_edge) begin
            w_acc_run = LP_HALF;
        end else if (w_tick) begin
            w_acc_run = w_acc_sum[31:0] - LP_CLK;
        end else begin
            w_acc_run = w_acc_sum[31:0];
        end
    end

    // Two-flop synchroniser plus one delayed copy for edge detection
    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            r_rx_meta <= 1'b1;
            r_rx_s    <= 1'b1;
            r_rx_d    <= 1'b1;
        end else begin
            r_rx_meta <= rx;
            r_rx_s    <= r_rx_meta;
            r_rx_d    <= r_rx_s;
        end
    end

    // Frame state machine with registered counters and status outputs
    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_acc        <= 32'd0;
            r_lfsr       <= LP_SEED;
            r_bit_cnt    <= 32'd0;
            r_rx_total   <= 32'd0;
            r_rx_err     <= 32'd0;
            r_busy       <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_frame_done <= 1'b0;
                    if (w_fall && (tbit_fre != 16'd0)) begin
                        r_acc   <= LP_HALF;
                        r_state <= ST_START;
                        r_busy  <= 1'b1;
                    end else begin
                        r_acc  <= 32'd0;
                        r_busy <= 1'b0;
                    end
                end
                ST_START: begin
                    r_acc <= w_acc_run;
                    if (w_tick) begin
                        if (!r_rx_s) begin
                            r_rx_total <= 32'd0;
                            r_rx_err   <= 32'd0;
                            r_bit_cnt  <= 32'd0;
                            r_lfsr     <= LP_SEED;
                            if (tx_total == 32'd0) begin
                                r_state      <= ST_DONE;
                                r_frame_done <= 1'b1;
                                r_acc        <= 32'd0;
                            end else begin
                                r_state <= ST_DATA;
                            end
                        end else begin
                            // Line was high again at mid start bit: a glitch
                            r_state <= ST_IDLE;
                            r_busy  <= 1'b0;
                            r_acc   <= 32'd0;
                        end
                    end else begin
                        r_state <= ST_START;
                    end
                end
                ST_DATA: begin
                    r_acc <= w_acc_run;
                    if (w_tick) begin
                        if (r_rx_s == w_expect) begin
                            r_rx_total <= r_rx_total + 32'd1;
                        end else begin
                            r_rx_err <= r_rx_err + 32'd1;
                        end
                        r_lfsr    <= f_lfsr_next(r_lfsr);
                        r_bit_cnt <= w_bit_next;
                        // >= keeps the block from running on if tx_total shrinks
                        if (w_bit_next >= tx_total) begin
                            r_state      <= ST_DONE;
                            r_frame_done <= 1'b1;
                            r_acc        <= 32'd0;
                        end else begin
                            r_state <= ST_DATA;
                        end
                    end else begin
                        r_state <= ST_DATA;
                    end
                end
                ST_DONE: begin
                    r_frame_done <= 1'b0;
                    r_busy       <= 1'b0;
                    r_acc        <= 32'd0;
                    r_state      <= ST_IDLE;
                end
                default: begin
                    r_state      <= ST_IDLE;
                    r_acc        <= 32'd0;
                    r_busy       <= 1'b0;
                    r_frame_done <= 1'b0;
                end
            endcase
        end
    end

    assign rx_total   = r_rx_total;
    assign rx_err     = r_rx_err;
    assign rx_busy    = r_busy;
    assign frame_done = r_frame_done;

endmodule

// File: tb/tb_commu_rx.sv
// -----------------------------------------------------------------------------
// tb_commu_rx
// Self-checking bench for commu_rx at CLK_KHZ=100000. Frames are driven on rx
// with a chosen bit period in clocks; expected counts come from a PRBS7
// sequence built by its recurrence f[k] = f[k-7]^f[k-6] (history seeded
// with ones), compared bit by bit against what was actually transmitted.
// -----------------------------------------------------------------------------
module tb_commu_rx;

    logic        clk_sys;
    logic        rst_n;
    logic        rx;
    logic [15:0] tbit_fre;
    logic [31:0] tx_total;
    logic [31:0] rx_total;
    logic [31:0] rx_err;
    logic        rx_busy;
    logic        frame_done;

    int nchk;
    int nerr;
    int done_cnt;
    int dbl_cnt;
    logic prev_done;
    logic prbs_ref [0:255];

    typedef struct {
        int period;
        int fre;
        int n;
        int flip;
        int exp_ok;
        int exp_bad;
    } vec_t;

    vec_t vecs [6];

    commu_rx #(.CLK_KHZ(100000)) dut (
        .clk_sys    (clk_sys),
        .rst_n      (rst_n),
        .rx         (rx),
        .tbit_fre   (tbit_fre),
        .tx_total   (tx_total),
        .rx_total   (rx_total),
        .rx_err     (rx_err),
        .rx_busy    (rx_busy),
        .frame_done (frame_done)
    );

    initial clk_sys = 1'b0;
    always #5 clk_sys = ~clk_sys;

    // Count frame_done pulses and any pulse wider than one cycle
    always @(negedge clk_sys) begin
        if (frame_done) done_cnt <= done_cnt + 1;
        if (frame_done && prev_done) dbl_cnt <= dbl_cnt + 1;
        prev_done <= frame_done;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Drive one frame. flip: index of a forced bit error (-1 none); err_pct:
    // random error rate; abort_at: data bit at which reset is pulsed (-1 none).
    task automatic send_frame(input int period, input int n, input int flip,
                              input int err_pct, input int abort_at,
                              output int exp_ok, output int exp_bad);
        int d0;
        int t;
        logic b;
        exp_ok  = 0;
        exp_bad = 0;
        d0 = done_cnt;
        rx = 1'b0;
        @(negedge clk_sys);
        @(negedge clk_sys);
        chk("busy_before_sync", {31'd0, rx_busy}, 32'd0);
        @(negedge clk_sys);
        chk("busy_after_sync", {31'd0, rx_busy}, 32'd1);
        repeat (period - 3) @(negedge clk_sys);
        for (int i = 0; i < n; i++) begin
            b = prbs_ref[i];
            if (i == flip || $urandom_range(99) < err_pct) b = ~b;
            if (i == abort_at) begin
                chk("busy_mid_frame", {31'd0, rx_busy}, 32'd1);
                rst_n = 1'b0;
                #1;
                chk("rst_total", rx_total, 32'd0);
                chk("rst_err", rx_err, 32'd0);
                chk("rst_busy", {31'd0, rx_busy}, 32'd0);
                chk("rst_done", {31'd0, frame_done}, 32'd0);
                @(negedge clk_sys);
                rx = 1'b1;
                @(negedge clk_sys);
                rst_n = 1'b1;
                repeat (20) @(negedge clk_sys);
                return;
            end
            if (b == prbs_ref[i]) exp_ok++;
            else exp_bad++;
            rx = b;
            repeat (period) @(negedge clk_sys);
        end
        rx = 1'b1;
        t = 0;
        while (t < 4 * period + 20 && done_cnt == d0) begin
            @(negedge clk_sys);
            t++;
        end
        repeat (period + 4) @(negedge clk_sys);
        chk("done_pulses", 32'(done_cnt - d0), 32'd1);
        chk("busy_after_frame", {31'd0, rx_busy}, 32'd0);
    endtask

    initial begin
        int ok;
        int bad;
        int d0;
        int seen_busy;
        int pers [6];
        int fres [6];
        int k;

        nchk = 0; nerr = 0; done_cnt = 0; dbl_cnt = 0; prev_done = 1'b0;

        // PRBS7 by recurrence; seed history (indices -7..-1) is all ones
        for (int i = 0; i < 256; i++) begin
            logic a;
            logic c;
            a = (i - 7 < 0) ? 1'b1 : prbs_ref[i - 7];
            c = (i - 6 < 0) ? 1'b1 : prbs_ref[i - 6];
            prbs_ref[i] = a ^ c;
        end

        vecs[0] = '{period: 20, fre: 5000,  n: 0,   flip: -1, exp_ok: 0,   exp_bad: 0};
        vecs[1] = '{period: 20, fre: 5000,  n: 100, flip: 10, exp_ok: 99,  exp_bad: 1};
        vecs[2] = '{period: 21, fre: 5000,  n: 100, flip: -1, exp_ok: 100, exp_bad: 0};
        vecs[3] = '{period: 10, fre: 10000, n: 37,  flip: 5,  exp_ok: 36,  exp_bad: 1};
        vecs[4] = '{period: 25, fre: 4000,  n: 60,  flip: -1, exp_ok: 60,  exp_bad: 0};
        vecs[5] = '{period: 20, fre: 5000,  n: 100, flip: -1, exp_ok: 100, exp_bad: 0};

        rst_n = 1'b0; rx = 1'b1; tbit_fre = 16'd5000; tx_total = 32'd0;
        repeat (3) @(negedge clk_sys);
        chk("reset_total", rx_total, 32'd0);
        chk("reset_err", rx_err, 32'd0);
        chk("reset_busy", {31'd0, rx_busy}, 32'd0);
        chk("reset_done", {31'd0, frame_done}, 32'd0);
        rst_n = 1'b1;
        repeat (10) @(negedge clk_sys);

        // Table-driven frames
        for (int v = 0; v < 6; v++) begin
            tbit_fre = 16'(vecs[v].fre);
            tx_total = 32'(vecs[v].n);
            send_frame(vecs[v].period, vecs[v].n, vecs[v].flip, 0, -1, ok, bad);
            chk("tbl_total", rx_total, 32'(vecs[v].exp_ok));
            chk("tbl_err", rx_err, 32'(vecs[v].exp_bad));
        end

        // Start-bit glitch: 3 clocks low, counters must keep 100/0
        d0 = done_cnt;
        rx = 1'b0;
        repeat (3) @(negedge clk_sys);
        rx = 1'b1;
        repeat (3) @(negedge clk_sys);
        chk("glitch_busy_start", {31'd0, rx_busy}, 32'd1);
        repeat (40) @(negedge clk_sys);
        chk("glitch_busy_end", {31'd0, rx_busy}, 32'd0);
        chk("glitch_total", rx_total, 32'd100);
        chk("glitch_err", rx_err, 32'd0);
        chk("glitch_no_done", 32'(done_cnt - d0), 32'd0);

        // Zero rate: a falling edge must never start a frame
        tbit_fre = 16'd0;
        seen_busy = 0;
        rx = 1'b0;
        repeat (40) begin
            @(negedge clk_sys);
            if (rx_busy) seen_busy++;
        end
        rx = 1'b1;
        repeat (10) @(negedge clk_sys);
        chk("zero_rate_busy", 32'(seen_busy), 32'd0);

        // Reset at data bit 50, then a clean frame
        tbit_fre = 16'd5000;
        tx_total = 32'd100;
        send_frame(20, 100, -1, 0, 50, ok, bad);
        send_frame(20, 100, -1, 0, -1, ok, bad);
        chk("post_reset_total", rx_total, 32'd100);
        chk("post_reset_err", rx_err, 32'd0);

        // Random frames against the PRBS model
        pers = '{40, 25, 20, 10, 5, 4};
        fres = '{2500, 4000, 5000, 10000, 20000, 25000};
        for (int r = 0; r < 8; r++) begin
            int n;
            k = $urandom_range(5);
            n = $urandom_range(80, 1);
            tbit_fre = 16'(fres[k]);
            tx_total = 32'(n);
            send_frame(pers[k], n, -1, 10, -1, ok, bad);
            chk("rnd_total", rx_total, 32'(ok));
            chk("rnd_err", rx_err, 32'(bad));
        end

        chk("done_width", 32'(dbl_cnt), 32'd0);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
